pfb_output_arbiter: RTL and testbench

- Frame-granular round-robin scheduler that shares the single output AXI-stream of the multichannel PFB write-outputs stage between NUM_CH per-lane streams.
- Transfers whole frames of FRAME_LEN beats and tags each frame with its channel id and TLAST.
- Per-lane starvation and output-backpressure watchdogs feed the cosim deadlock monitors.

---
 rtl/pfb_arb_pkg.sv | 28 ++
 rtl/pfb_stall_watchdog.sv | 31 +++
 rtl/pfb_output_arbiter.sv | 165 ++++++++++++++++
 tb/tb_pfb_output_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pfb_arb_pkg.sv
// Shared types, default sizing and helpers for the PFB output arbiter.
// Imported by the arbiter top and its stall watchdog.
package pfb_arb_pkg;

    localparam int DEFAULT_NUM_CH      = 4;
    localparam int DEFAULT_DATA_W      = 32;
    localparam int DEFAULT_FRAME_LEN   = 256;
    localparam int DEFAULT_STALL_LIMIT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_e;

    // Smallest r with 2**r >= value; usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pfb_stall_watchdog.sv
// Saturating stall counter with a flag raised once LIMIT consecutive stall
// cycles have been seen; clear restarts the streak.
module pfb_stall_watchdog
    import pfb_arb_pkg::*;
#(
    parameter  int LIMIT = DEFAULT_STALL_LIMIT,
    localparam int CNT_W = (clog2(LIMIT + 1) > 0) ? clog2(LIMIT + 1) : 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_stall_cond,
    input  logic i_clear,
    output logic o_flag
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_count;

    // NOTE: clear has priority, so the first stall after a handshake counts as 1, not as a continuation.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_stall_cond && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_flag = (r_count == CNT_MAX);

endmodule

// File: rtl/pfb_output_arbiter.sv
// Frame-granular round-robin arbiter merging NUM_CH AXI-stream lanes onto one
// registered output, tagging each beat with its lane id and frame TLAST.
module pfb_output_arbiter
    import pfb_arb_pkg::*;
#(
    parameter  int NUM_CH      = DEFAULT_NUM_CH,
    parameter  int DATA_W      = DEFAULT_DATA_W,
    parameter  int FRAME_LEN   = DEFAULT_FRAME_LEN,
    parameter  int STALL_LIMIT = DEFAULT_STALL_LIMIT,
    localparam int CH_W        = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic [NUM_CH*DATA_W-1:0] i_s_tdata,
    input  logic [NUM_CH-1:0]        i_s_tvalid,
    output logic [NUM_CH-1:0]        o_s_tready,
    output logic [DATA_W-1:0]        o_m_tdata,
    output logic                     o_m_tvalid,
    input  logic                     i_m_tready,
    output logic                     o_m_tlast,
    output logic [CH_W-1:0]          o_m_tuser,
    output logic                     o_busy,
    output logic                     o_out_block,
    output logic [NUM_CH-1:0]        o_starve
);

    localparam logic [15:0] LAST_IDX  = 16'(FRAME_LEN - 1);
    localparam logic [15:0] FRAME_END = 16'(FRAME_LEN);

    arb_state_e        r_state;
    logic [CH_W-1:0]   r_ptr;
    logic [CH_W-1:0]   r_grant;
    logic [15:0]       r_count;

    logic              r_m_tvalid;
    logic              r_m_tlast;
    logic [DATA_W-1:0] r_m_tdata;
    logic [CH_W-1:0]   r_m_tuser;

    logic              w_out_free;
    logic              w_lane_ready;
    logic              w_accept;
    logic              w_last_accept;
    logic              w_found;
    logic [CH_W-1:0]   w_pick;
    logic [CH_W-1:0]   w_cand;
    logic [DATA_W-1:0] w_lane_data;
    logic              w_out_hs;
    logic              w_out_stall;

    // The output stage can take a beat when empty or draining this cycle.
    assign w_out_free    = ~r_m_tvalid | i_m_tready;
    assign w_lane_ready  = (r_state == ST_XFER) & w_out_free & (r_count < FRAME_END);
    assign w_accept      = w_lane_ready & i_s_tvalid[r_grant];
    assign w_last_accept = w_accept & (r_count == LAST_IDX);
    assign w_lane_data   = i_s_tdata[r_grant*DATA_W +: DATA_W];

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_cand  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_cand = CH_W'((int'(r_ptr) + k) % NUM_CH);
            if (!w_found && i_s_tvalid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= CH_W'(NUM_CH - 1);
            r_grant <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_count <= r_count + 16'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_enable && (|i_s_tvalid)) begin
                        r_state <= ST_ARB;
                        r_count <= '0;
                    end
                end
                ST_ARB: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_ptr   <= w_pick;
                        r_state <= ST_XFER;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    // enable only decides whether another frame follows this one.
                    if (w_last_accept) begin
                        if (i_enable) begin
                            r_state <= ST_ARB;
                            r_count <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tuser  <= '0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= (r_count == LAST_IDX);
            r_m_tdata  <= w_lane_data;
            r_m_tuser  <= r_grant;
        end else if (i_m_tready) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end
    end

    assign o_s_tready = w_lane_ready ? (NUM_CH'(1) << r_grant) : '0;
    assign o_m_tvalid = r_m_tvalid;
    assign o_m_tlast  = r_m_tlast;
    assign o_m_tdata  = r_m_tdata;
    assign o_m_tuser  = r_m_tuser;
    assign o_busy     = (r_state == ST_XFER);

    assign w_out_hs    = r_m_tvalid & i_m_tready;
    assign w_out_stall = r_m_tvalid & ~i_m_tready;

    pfb_stall_watchdog #(
        .LIMIT (STALL_LIMIT)
    ) u_out_watchdog (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_stall_cond (w_out_stall),
        .i_clear      (w_out_hs),
        .o_flag       (o_out_block)
    );

    // A lane's streak ends on its handshake or when it stops requesting.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_starve
        pfb_stall_watchdog #(
            .LIMIT (STALL_LIMIT)
        ) u_lane_watchdog (
            .i_clock      (i_clock),
            .i_reset      (i_reset),
            .i_stall_cond (i_s_tvalid[gi] & ~o_s_tready[gi]),
            .i_clear      (~i_s_tvalid[gi] | o_s_tready[gi]),
            .o_flag       (o_starve[gi])
        );
    end

endmodule

// File: tb/tb_pfb_output_arbiter.sv
// Directed bench for pfb_output_arbiter with FRAME_LEN=4 and STALL_LIMIT=8.
// Lanes source {lane id, per-lane sequence}; output beats are logged at negedge.
module tb_pfb_output_arbiter;

    localparam int NCH  = 4;
    localparam int DW   = 32;
    localparam int FLEN = 4;
    localparam int SLIM = 8;

    typedef struct packed {
        logic [1:0]  user;
        logic        last;
        logic [31:0] data;
    } beat_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic [NCH*DW-1:0] s_tdata;
    logic [NCH-1:0]    s_tvalid;
    logic [NCH-1:0]    s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic [1:0]        m_tuser;
    logic              busy;
    logic              out_block;
    logic [NCH-1:0]    starve;

    beat_t beats[$];
    int    stamps[$];
    int    cyc_cnt = 0;
    int    seq[NCH];
    int    n_total = 0;
    int    n_bad   = 0;
    logic [7:0] rdy_pat;
    beat_t snap;
    logic  snap_v;

    always #5 clock = ~clock;

    pfb_output_arbiter #(
        .NUM_CH      (NCH),
        .DATA_W      (DW),
        .FRAME_LEN   (FLEN),
        .STALL_LIMIT (SLIM)
    ) dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_enable    (enable),
        .i_s_tdata   (s_tdata),
        .i_s_tvalid  (s_tvalid),
        .o_s_tready  (s_tready),
        .o_m_tdata   (m_tdata),
        .o_m_tvalid  (m_tvalid),
        .i_m_tready  (m_tready),
        .o_m_tlast   (m_tlast),
        .o_m_tuser   (m_tuser),
        .o_busy      (busy),
        .o_out_block (out_block),
        .o_starve    (starve)
    );

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            s_tdata[i*DW +: DW] = {8'(i), 24'(seq[i])};
        end
    end

    always @(posedge clock) begin
        cyc_cnt <= cyc_cnt + 1;
        for (int i = 0; i < NCH; i++) begin
            if (reset) seq[i] <= 0;
            else if (s_tvalid[i] && s_tready[i]) seq[i] <= seq[i] + 1;
        end
    end

    always @(negedge clock) begin
        if (!reset && m_tvalid && m_tready) begin
            beats.push_back({m_tuser, m_tlast, m_tdata});
            stamps.push_back(cyc_cnt);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic beat_t mk(input int lane, input int s, input logic last);
        return {2'(lane), last, 8'(lane), 24'(s)};
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        enable   = 1'b0;
        s_tvalid = '0;
        m_tready = 1'b0;
        cyc();
        cyc();
        beats.delete();
        stamps.delete();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int g = 0;
        while (!m_tvalid && g < budget) begin
            cyc();
            g++;
        end
        check(tag, 64'(m_tvalid), 64'd1);
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int g = 0;
        while (beats.size() < n && g < budget) begin
            cyc();
            g++;
        end
        check(tag, 64'(beats.size()), 64'(n));
    endtask

    task automatic check_frame(input string tag, input int base, input int lane, input int s0);
        for (int j = 0; j < FLEN; j++) begin
            if (base + j < beats.size())
                check($sformatf("%s_b%0d", tag, j), 64'(beats[base+j]), 64'(mk(lane, s0 + j, j == FLEN - 1)));
            else
                check($sformatf("%s_missing%0d", tag, j), 64'(beats.size()), 64'(base + j + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        do_reset();
        reset = 1'b1;
        cyc();
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tdata",  64'(m_tdata),  64'd0);
        check("rst_tlast",  64'(m_tlast),  64'd0);
        check("rst_tuser",  64'(m_tuser),  64'd0);
        check("rst_busy",   64'(busy),     64'd0);
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_block",  64'(out_block), 64'd0);
        check("rst_starve", 64'(starve),   64'd0);

        // Single requester: lane 0 streams, re-granted every frame
        do_reset();
        enable = 1'b1; m_tready = 1'b1; s_tvalid = 4'b0001;
        cyc();
        check("t1_arb_busy",   64'(busy),     64'd0);
        check("t1_arb_tvalid", 64'(m_tvalid), 64'd0);
        cyc();
        check("t1_xfer_busy",   64'(busy),     64'd1);
        check("t1_xfer_tvalid", 64'(m_tvalid), 64'd0);
        check("t1_xfer_tready", 64'(s_tready), 64'd1);
        cyc();
        check("t1_first_beat", 64'({m_tvalid, m_tuser, m_tlast, m_tdata}), 64'({1'b1, mk(0, 0, 1'b0)}));
        wait_beats("t1_nbeats", 12, 100);
        check_frame("t1_f0", 0, 0, 0);
        check_frame("t1_f1", 4, 0, 4);
        check_frame("t1_f2", 8, 0, 8);
        if (beats.size() >= 12) begin
            check("t1_gap_in",     64'(stamps[1] - stamps[0]), 64'd1);
            check("t1_gap_frame1", 64'(stamps[4] - stamps[3]), 64'd2);
            check("t1_gap_frame2", 64'(stamps[8] - stamps[7]), 64'd2);
        end

        // All lanes requesting: frames rotate 0,1,2,3,0
        do_reset();
        enable = 1'b1; m_tready = 1'b1; s_tvalid = 4'b1111;
        wait_beats("t2_nbeats", 20, 200);
        for (int f = 0; f < 5; f++) begin
            check_frame($sformatf("t2_f%0d", f), f * FLEN, f % NCH, (f / NCH) * FLEN);
        end

        // Output stalls mid-frame: held beats, nothing lost or duplicated
        do_reset();
        enable = 1'b1; m_tready = 1'b1; s_tvalid = 4'b0100;
        wait_valid("t3_valid", 10);
        enable  = 1'b0;
        rdy_pat = 8'b11101001;
        for (int i = 0; i < 8; i++) begin
            m_tready = rdy_pat[i];
            snap     = {m_tuser, m_tlast, m_tdata};
            snap_v   = m_tvalid;
            cyc();
            if (snap_v && !rdy_pat[i]) begin
                check($sformatf("t3_hold%0d", i), 64'({m_tvalid, m_tuser, m_tlast, m_tdata}), 64'({1'b1, snap}));
            end
        end
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        check("t3_nbeats", 64'(beats.size()), 64'(FLEN));
        check_frame("t3_f0", 0, 2, 0);

        // Output backpressure watchdog and lane starvation while stalled
        do_reset();
        enable = 1'b1; s_tvalid = 4'b0010;
        wait_valid("t4_valid", 10);
        snap = {m_tuser, m_tlast, m_tdata};
        for (int k = 1; k <= 9; k++) begin
            cyc();
            if (k == 7) begin
                check("t4_block_7",  64'(out_block), 64'd0);
                check("t4_starve_7", 64'(starve),    64'd0);
            end
            if (k == 8) begin
                check("t4_block_8",  64'(out_block), 64'd1);
                check("t4_starve_8", 64'(starve),    64'b0010);
            end
            if (k == 9) check("t4_block_9", 64'(out_block), 64'd1);
        end
        check("t4_held", 64'({m_tuser, m_tlast, m_tdata}), 64'(snap));
        m_tready = 1'b1;
        cyc();
        check("t4_block_clr",  64'(out_block), 64'd0);
        check("t4_starve_clr", 64'(starve),    64'd0);

        // enable dropped mid-frame: frame completes, no new grant, then resume at pointer+1
        do_reset();
        enable = 1'b1; m_tready = 1'b1; s_tvalid = 4'b0001;
        wait_valid("t5_valid", 10);
        enable = 1'b0;
        wait_beats("t5_nbeats", 4, 40);
        check_frame("t5_f0", 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc();
        check("t5_idle_busy",   64'(busy),         64'd0);
        check("t5_idle_tvalid", 64'(m_tvalid),     64'd0);
        check("t5_idle_nbeats", 64'(beats.size()), 64'd4);
        check("t5_starve_set",  64'(starve),       64'b0001);
        s_tvalid = 4'b0000;
        cyc();
        check("t5_starve_drop", 64'(starve), 64'd0);
        s_tvalid = 4'b0011; enable = 1'b1;
        wait_beats("t5_resume_n", 8, 60);
        check_frame("t5_resume", 4, 1, 0);

        // Reset mid-frame abandons the frame and restores lane 0 priority
        do_reset();
        enable = 1'b1; m_tready = 1'b1; s_tvalid = 4'b0100;
        wait_valid("t6_valid", 10);
        cyc();
        reset = 1'b1;
        cyc();
        check("t6_tvalid", 64'(m_tvalid),  64'd0);
        check("t6_tdata",  64'(m_tdata),   64'd0);
        check("t6_tlast",  64'(m_tlast),   64'd0);
        check("t6_tuser",  64'(m_tuser),   64'd0);
        check("t6_busy",   64'(busy),      64'd0);
        check("t6_tready", 64'(s_tready),  64'd0);
        check("t6_block",  64'(out_block), 64'd0);
        check("t6_starve", 64'(starve),    64'd0);
        check("t6_partial_n", 64'(beats.size()), 64'd1);
        if (beats.size() >= 1) check("t6_partial_b0", 64'(beats[0]), 64'(mk(2, 0, 1'b0)));
        beats.delete();
        stamps.delete();
        reset = 1'b0; s_tvalid = 4'b0101;
        wait_beats("t6_nbeats", 4, 40);
        check_frame("t6_f0", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
